// File: rtl/vram_pkg.sv
// Shared definitions for the video SRAM arbiter.
// Provides:
//   - VRAM_ADDR_W and VRAM_DATA_W: geometry of the 64Kx8 video SRAM port.
//   - SRAM_READ_LATENCY: edges from address sample to valid read data.
//   - tag_t: the owner of an in-flight read (none, CPU or video).
package vram_pkg;

   localparam int VRAM_ADDR_W       = 16;
   localparam int VRAM_DATA_W       = 8;
   localparam int SRAM_READ_LATENCY = 2;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CPU  = 2'd1,
      TAG_VID  = 2'd2
   } tag_t;

endpackage

// File: rtl/vram_return_pipe.sv
// Read return path of the video SRAM arbiter.
// Carries the owner tag of each issued access alongside the SRAM's two-edge read
// latency. It then steers the byte coming out of the SRAM to the requester that
// issued the read.
// Ports:
//   clk, reset     clock and asynchronous active-high reset
//   issue_tag      owner of the access issued this cycle (tag_t encoding)
//   sram_data_out  SRAM read data for the address sampled two edges earlier
//   cpu_rdata      registered CPU read data, held between pulses
//   cpu_rvalid     one-cycle pulse qualifying cpu_rdata
//   vid_rdata      registered video read data, held between pulses
//   vid_rvalid     one-cycle pulse qualifying vid_rdata
module vram_return_pipe
   import vram_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             issue_tag,
   input  logic [VRAM_DATA_W-1:0] sram_data_out,
   output logic [VRAM_DATA_W-1:0] cpu_rdata,
   output logic                   cpu_rvalid,
   output logic [VRAM_DATA_W-1:0] vid_rdata,
   output logic                   vid_rvalid
);

   tag_t tag_p0;
   tag_t tag_p1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_p0     <= TAG_NONE;
         tag_p1     <= TAG_NONE;
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
         vid_rdata  <= '0;
         vid_rvalid <= 1'b0;
      end else begin
         // p0: edge on which the SRAM samples the address
         tag_p0 <= tag_t'(issue_tag);
         // p1: edge on which the SRAM presents the data
         tag_p1 <= tag_p0;
         // capture: data is on sram_data_out while tag_p1 names its owner
         cpu_rvalid <= (tag_p1 == TAG_CPU);
         vid_rvalid <= (tag_p1 == TAG_VID);
         if (tag_p1 == TAG_CPU) begin
            cpu_rdata <= sram_data_out;
         end
         if (tag_p1 == TAG_VID) begin
            vid_rdata <= sram_data_out;
         end
      end
   end

endmodule

// File: rtl/vram_arbiter.sv
// Two-port arbiter in front of the 64Kx8 video SRAM.
// A CPU port (read/write) and a video scan-out port (read-only) compete for the
// SRAM each cycle. Video wins ties unless the CPU has already lost CPU_MAX_WAIT
// times in a row, in which case the CPU is forced through. Reads are fully
// pipelined; each returned byte is routed back to the requester that issued it.
// Ports:
//   clk, reset                         clock and asynchronous active-high reset
//   cpu_req/we/addr/wdata              CPU request, held until cpu_ack
//   cpu_ack                            combinational; CPU access issued this cycle
//   cpu_rdata, cpu_rvalid              CPU read return, 3 cycles after the ack
//   vid_req/addr                       video read request, held until vid_ack
//   vid_ack                            combinational; video read issued this cycle
//   vid_rdata, vid_rvalid              video read return, 3 cycles after the ack
//   sram_addr/data_in/write_enable     drive to the SRAM
//   sram_data_out                      SRAM read data
module vram_arbiter
   import vram_pkg::*;
#(
   parameter int CPU_MAX_WAIT = 4,
   parameter int WAIT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic        cpu_rvalid,
   input  logic        vid_req,
   input  logic [15:0] vid_addr,
   output logic        vid_ack,
   output logic [7:0]  vid_rdata,
   output logic        vid_rvalid,
   output logic [15:0] sram_addr,
   output logic [7:0]  sram_data_in,
   output logic        sram_write_enable,
   input  logic [7:0]  sram_data_out
);

   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(CPU_MAX_WAIT);

   logic [WAIT_W-1:0]      wait_cnt;
   logic [VRAM_ADDR_W-1:0] addr_q;
   logic                   force_cpu;
   logic                   grant_cpu;
   logic                   grant_vid;
   tag_t                   issue_tag;

   // Counts CPU losses, sticking at the limit so force_cpu stays asserted.
   function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
      if (v >= WAIT_LIMIT) begin
         return WAIT_LIMIT;
      end
      return v + WAIT_W'(1);
   endfunction

   // Grant is decided and driven to the SRAM within the request cycle. Reset
   // blocks both grants so nothing reaches the SRAM while it is held.
   always_comb begin
      force_cpu         = (wait_cnt >= WAIT_LIMIT);
      grant_cpu         = !reset && cpu_req && (!vid_req || force_cpu);
      grant_vid         = !reset && vid_req && !grant_cpu;
      sram_addr         = addr_q;
      sram_data_in      = '0;
      sram_write_enable = 1'b0;
      issue_tag         = TAG_NONE;
      if (grant_cpu) begin
         sram_addr         = cpu_addr;
         sram_data_in      = cpu_wdata;
         sram_write_enable = cpu_we;
         issue_tag         = cpu_we ? TAG_NONE : TAG_CPU;
      end else if (grant_vid) begin
         sram_addr = vid_addr;
         issue_tag = TAG_VID;
      end
   end

   assign cpu_ack = grant_cpu;
   assign vid_ack = grant_vid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
         addr_q   <= '0;
      end else begin
         // p0: request consumed; remember the address for idle cycles
         if (grant_cpu) begin
            wait_cnt <= '0;
            addr_q   <= cpu_addr;
         end else begin
            if (cpu_req) begin
               wait_cnt <= sat_inc(wait_cnt);
            end
            if (grant_vid) begin
               addr_q <= vid_addr;
            end
         end
      end
   end

   vram_return_pipe u_return_pipe (
      .clk           (clk),
      .reset         (reset),
      .issue_tag     (issue_tag),
      .sram_data_out (sram_data_out),
      .cpu_rdata     (cpu_rdata),
      .cpu_rvalid    (cpu_rvalid),
      .vid_rdata     (vid_rdata),
      .vid_rvalid    (vid_rvalid)
   );

endmodule

// File: tb/tb_vram_arbiter.sv
// Testbench for vram_arbiter: a behavioural 64Kx8 SRAM with a two-edge read
// latency, directed scenarios, and a randomized run checked against a
// transaction-level reference model.
module tb_vram_arbiter;

   localparam int MAXW = 4;
   localparam int N    = 400;

   logic        clk = 1'b0;
   logic        reset;
   logic        cpu_req, cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack, cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        vid_req;
   logic [15:0] vid_addr;
   logic        vid_ack, vid_rvalid;
   logic [7:0]  vid_rdata;
   logic [15:0] sram_addr;
   logic [7:0]  sram_data_in;
   logic        sram_write_enable;
   logic [7:0]  sram_data_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vram_arbiter #(.CPU_MAX_WAIT(MAXW), .WAIT_W(4)) dut (
      .clk               (clk),
      .reset             (reset),
      .cpu_req           (cpu_req),
      .cpu_we            (cpu_we),
      .cpu_addr          (cpu_addr),
      .cpu_wdata         (cpu_wdata),
      .cpu_ack           (cpu_ack),
      .cpu_rdata         (cpu_rdata),
      .cpu_rvalid        (cpu_rvalid),
      .vid_req           (vid_req),
      .vid_addr          (vid_addr),
      .vid_ack           (vid_ack),
      .vid_rdata         (vid_rdata),
      .vid_rvalid        (vid_rvalid),
      .sram_addr         (sram_addr),
      .sram_data_in      (sram_data_in),
      .sram_write_enable (sram_write_enable),
      .sram_data_out     (sram_data_out)
   );

   // Unwritten locations read back as a fixed pattern of their address.
   function automatic logic [7:0] init_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   // SRAM model: address sampled on one edge, data presented on the next.
   bit   [7:0]  mem [0:65535];
   bit          wr  [0:65535];
   logic [15:0] rd_addr_q = '0;

   always @(posedge clk) begin
      if (sram_write_enable) begin
         mem[sram_addr] <= sram_data_in;
         wr[sram_addr]  <= 1'b1;
      end
      rd_addr_q     <= sram_addr;
      sram_data_out <= wr[rd_addr_q] ? mem[rd_addr_q] : init_val(rd_addr_q);
   end

   // Reference memory contents as seen by issued accesses.
   logic [7:0] ref_mem [int];

   function automatic logic [7:0] ref_read(input logic [15:0] a);
      if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
      return init_val(a);
   endfunction

   task automatic idle_inputs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      vid_req = 1'b0; vid_addr = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h4444; cpu_wdata = 8'h77;
      vid_req = 1'b1; vid_addr = 16'h5555;
      #1;
      n_cmp++; if (cpu_ack !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_ack: got %b want 0", cpu_ack); end
      n_cmp++; if (vid_ack !== 1'b0) begin n_bad++; $display("FAIL rst_vid_ack: got %b want 0", vid_ack); end
      n_cmp++; if (sram_write_enable !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", sram_write_enable); end
      n_cmp++; if (sram_addr !== 16'h0000) begin n_bad++; $display("FAIL rst_addr: got %h want 0000", sram_addr); end
      n_cmp++; if ({cpu_rvalid, vid_rvalid} !== 2'b00) begin n_bad++; $display("FAIL rst_rvalid: got %b want 00", {cpu_rvalid, vid_rvalid}); end
      n_cmp++; if ({cpu_rdata, vid_rdata} !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata: got %h want 0000", {cpu_rdata, vid_rdata}); end
      @(negedge clk);
      idle_inputs();
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_cpu_write_read();
      @(negedge clk);
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h1234; cpu_wdata = 8'hA5;
      #1;
      n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL wr_ack: got %b want 1", cpu_ack); end
      n_cmp++; if (sram_write_enable !== 1'b1) begin n_bad++; $display("FAIL wr_we: got %b want 1", sram_write_enable); end
      n_cmp++; if ({sram_addr, sram_data_in} !== {16'h1234, 8'hA5}) begin n_bad++; $display("FAIL wr_drive: got %h want 1234a5", {sram_addr, sram_data_in}); end
      @(negedge clk);
      cpu_we = 1'b0; cpu_wdata = 8'h00;
      #1;
      n_cmp++; if (cpu_ack !== 1'b1) begin n_bad++; $display("FAIL rd_ack: got %b want 1", cpu_ack); end
      n_cmp++; if (sram_write_enable !== 1'b0) begin n_bad++; $display("FAIL rd_we: got %b want 0", sram_write_enable); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         if (k == 1) begin
            n_cmp++; if ({sram_addr, sram_data_in, sram_write_enable} !== {16'h1234, 8'h00, 1'b0}) begin
               n_bad++; $display("FAIL idle_drive: got %h/%h/%b want 1234/00/0", sram_addr, sram_data_in, sram_write_enable);
            end
         end
         n_cmp++; if (cpu_rvalid !== (k == 3)) begin n_bad++; $display("FAIL rd_rvalid k=%0d: got %b want %b", k, cpu_rvalid, (k == 3)); end
         n_cmp++; if (vid_rvalid !== 1'b0) begin n_bad++; $display("FAIL rd_vid_rvalid k=%0d: got %b want 0", k, vid_rvalid); end
         if (k >= 3) begin
            n_cmp++; if (cpu_rdata !== 8'hA5) begin n_bad++; $display("FAIL rd_data k=%0d: got %h want a5", k, cpu_rdata); end
         end
      end
      ref_mem[int'(16'h1234)] = 8'hA5;
   endtask

   task automatic test_video_burst();
      logic [7:0] want;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (k < 8) begin
            vid_req = 1'b1; vid_addr = 16'(k);
         end else begin
            idle_inputs();
         end
         #1;
         if (k < 8) begin
            n_cmp++; if (vid_ack !== 1'b1) begin n_bad++; $display("FAIL burst_ack k=%0d: got %b want 1", k, vid_ack); end
         end
         n_cmp++; if (vid_rvalid !== (k >= 3 && k < 11)) begin n_bad++; $display("FAIL burst_rvalid k=%0d: got %b want %b", k, vid_rvalid, (k >= 3 && k < 11)); end
         if (k >= 3 && k < 11) begin
            want = 8'h5A ^ 8'(k - 3);
            n_cmp++; if (vid_rdata !== want) begin n_bad++; $display("FAIL burst_data k=%0d: got %h want %h", k, vid_rdata, want); end
         end
         n_cmp++; if (cpu_rvalid !== 1'b0) begin n_bad++; $display("FAIL burst_cpu_rvalid k=%0d: got %b want 0", k, cpu_rvalid); end
      end
   endtask

   task automatic test_starvation();
      for (int k = 1; k <= 14; k++) begin
         @(negedge clk);
         if (k <= 10) begin
            vid_req = 1'b1; vid_addr = 16'h0100 + 16'(k);
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = (k <= 5) ? 16'h0042 : 16'h0043;
         end else begin
            idle_inputs();
         end
         #1;
         if (k <= 10) begin
            n_cmp++; if (cpu_ack !== (k == 5 || k == 10)) begin n_bad++; $display("FAIL starve_cpu_ack k=%0d: got %b want %b", k, cpu_ack, (k == 5 || k == 10)); end
            n_cmp++; if (vid_ack !== !(k == 5 || k == 10)) begin n_bad++; $display("FAIL starve_vid_ack k=%0d: got %b want %b", k, vid_ack, !(k == 5 || k == 10)); end
         end
         if (k == 8) begin
            n_cmp++; if ({cpu_rvalid, vid_rvalid, cpu_rdata} !== {2'b10, 8'h18}) begin n_bad++; $display("FAIL starve_ret1: got %b%b/%h want 10/18", cpu_rvalid, vid_rvalid, cpu_rdata); end
         end
         if (k == 13) begin
            n_cmp++; if ({cpu_rvalid, vid_rvalid, cpu_rdata} !== {2'b10, 8'h19}) begin n_bad++; $display("FAIL starve_ret2: got %b%b/%h want 10/19", cpu_rvalid, vid_rvalid, cpu_rdata); end
         end
      end
   endtask

   task automatic test_interleave();
      logic [1:0] want_v [7];
      logic [7:0] want_d [7];
      want_v = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
      want_d = '{8'h00, 8'h00, 8'h00, 8'hDB, 8'h5B, 8'hD8, 8'h00};
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 0) begin vid_req = 1'b1; vid_addr = 16'h8001; end
         if (k == 1) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0001; end
         if (k == 2) begin vid_req = 1'b1; vid_addr = 16'h8002; end
         #1;
         if (k < 3) begin
            n_cmp++; if ({cpu_ack, vid_ack} !== ((k == 1) ? 2'b10 : 2'b01)) begin n_bad++; $display("FAIL ilv_ack k=%0d: got %b%b", k, cpu_ack, vid_ack); end
         end
         n_cmp++; if ({cpu_rvalid, vid_rvalid} !== want_v[k]) begin n_bad++; $display("FAIL ilv_rvalid k=%0d: got %b%b want %b", k, cpu_rvalid, vid_rvalid, want_v[k]); end
         if (want_v[k] == 2'b01) begin
            n_cmp++; if (vid_rdata !== want_d[k]) begin n_bad++; $display("FAIL ilv_vdata k=%0d: got %h want %h", k, vid_rdata, want_d[k]); end
         end
         if (want_v[k] == 2'b10) begin
            n_cmp++; if (cpu_rdata !== want_d[k]) begin n_bad++; $display("FAIL ilv_cdata k=%0d: got %h want %h", k, cpu_rdata, want_d[k]); end
         end
      end
   endtask

   task automatic test_collision();
      for (int k = 0; k < 7; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 0) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00C0; cpu_wdata = 8'h3C;
            vid_req = 1'b1; vid_addr = 16'h0010;
         end
         if (k == 1) begin cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h00C0; cpu_wdata = 8'h3C; end
         if (k == 2) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h00C0; end
         #1;
         if (k == 0) begin
            n_cmp++; if ({cpu_ack, vid_ack, sram_write_enable} !== 3'b010) begin n_bad++; $display("FAIL coll_c0: got ack %b%b we %b want 01/0", cpu_ack, vid_ack, sram_write_enable); end
            n_cmp++; if (sram_addr !== 16'h0010) begin n_bad++; $display("FAIL coll_c0_addr: got %h want 0010", sram_addr); end
         end
         if (k == 1) begin
            n_cmp++; if ({cpu_ack, sram_write_enable, sram_addr, sram_data_in} !== {2'b11, 16'h00C0, 8'h3C}) begin
               n_bad++; $display("FAIL coll_c1: got %b%b %h %h want 11 00c0 3c", cpu_ack, sram_write_enable, sram_addr, sram_data_in);
            end
         end
         if (k == 3) begin
            n_cmp++; if ({vid_rvalid, vid_rdata} !== {1'b1, 8'h4A}) begin n_bad++; $display("FAIL coll_vret: got %b/%h want 1/4a", vid_rvalid, vid_rdata); end
         end
         if (k == 5) begin
            n_cmp++; if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'h3C}) begin n_bad++; $display("FAIL coll_cret: got %b/%h want 1/3c", cpu_rvalid, cpu_rdata); end
         end
      end
      ref_mem[int'(16'h00C0)] = 8'h3C;
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         idle_inputs();
         if (k == 0) begin vid_req = 1'b1; vid_addr = 16'h0005; end
         if (k == 1) reset = 1'b1;
         if (k == 3) reset = 1'b0;
         if (k == 7) begin vid_req = 1'b1; vid_addr = 16'h0006; end
         #1;
         if (k == 0 || k == 7) begin
            n_cmp++; if (vid_ack !== 1'b1) begin n_bad++; $display("FAIL rmid_ack k=%0d: got %b want 1", k, vid_ack); end
         end
         if (k == 1 || k == 2) begin
            n_cmp++; if ({cpu_rdata, vid_rdata, cpu_rvalid, vid_rvalid, sram_addr, sram_write_enable} !== 35'd0) begin
               n_bad++; $display("FAIL rmid_rstvals k=%0d: got %h %h %b %b %h %b", k, cpu_rdata, vid_rdata, cpu_rvalid, vid_rvalid, sram_addr, sram_write_enable);
            end
         end
         if (k >= 1 && k < 10) begin
            n_cmp++; if (vid_rvalid !== 1'b0) begin n_bad++; $display("FAIL rmid_norvalid k=%0d: got %b want 0", k, vid_rvalid); end
         end
         if (k == 10) begin
            n_cmp++; if ({vid_rvalid, vid_rdata} !== {1'b1, 8'h5C}) begin n_bad++; $display("FAIL rmid_after: got %b/%h want 1/5c", vid_rvalid, vid_rdata); end
         end
      end
   endtask

   // Randomized traffic. The reference tracks each requester as a pending
   // transaction and the number of consecutive cycles the CPU has been
   // refused; every issued read is scheduled to return three cycles later
   // with the memory contents as of issue time.
   task automatic test_random();
      bit          c_pend = 0, v_pend = 0, c_we_r = 0;
      logic [15:0] c_addr_r = '0, v_addr_r = '0;
      logic [7:0]  c_wdata_r = '0;
      int          refused = 0;
      bit          e_gc, e_gv;
      bit          exp_cv [N + 16];
      bit          exp_vv [N + 16];
      logic [7:0]  exp_cd [N + 16];
      logic [7:0]  exp_vd [N + 16];
      for (int i = 0; i < N + 16; i++) begin
         exp_cv[i] = 0; exp_vv[i] = 0; exp_cd[i] = '0; exp_vd[i] = '0;
      end
      for (int k = 0; k < N + 12; k++) begin
         @(negedge clk);
         if (k < N && !c_pend && $urandom_range(0, 2) == 0) begin
            c_pend = 1; c_we_r = ($urandom_range(0, 1) == 1);
            c_addr_r = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) c_addr_r[15] = 1'b1;
            c_wdata_r = 8'($urandom);
         end
         if (k < N && !v_pend && $urandom_range(0, 3) != 0) begin
            v_pend = 1;
            v_addr_r = 16'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) v_addr_r[15] = 1'b1;
         end
         cpu_req = c_pend; cpu_we = c_we_r; cpu_addr = c_addr_r; cpu_wdata = c_wdata_r;
         vid_req = v_pend; vid_addr = v_addr_r;
         #1;
         e_gc = c_pend && (!v_pend || refused >= MAXW);
         e_gv = v_pend && !e_gc;
         n_cmp++; if ({cpu_ack, vid_ack} !== {e_gc, e_gv}) begin n_bad++; $display("FAIL rnd_ack k=%0d: got %b%b want %b%b", k, cpu_ack, vid_ack, e_gc, e_gv); end
         n_cmp++; if (sram_write_enable !== (e_gc && c_we_r)) begin n_bad++; $display("FAIL rnd_we k=%0d: got %b want %b", k, sram_write_enable, e_gc && c_we_r); end
         if (e_gc || e_gv) begin
            n_cmp++; if (sram_addr !== (e_gc ? c_addr_r : v_addr_r)) begin n_bad++; $display("FAIL rnd_addr k=%0d: got %h want %h", k, sram_addr, e_gc ? c_addr_r : v_addr_r); end
         end
         n_cmp++; if ({cpu_rvalid, vid_rvalid} !== {exp_cv[k], exp_vv[k]}) begin n_bad++; $display("FAIL rnd_rvalid k=%0d: got %b%b want %b%b", k, cpu_rvalid, vid_rvalid, exp_cv[k], exp_vv[k]); end
         if (exp_cv[k]) begin
            n_cmp++; if (cpu_rdata !== exp_cd[k]) begin n_bad++; $display("FAIL rnd_cdata k=%0d: got %h want %h", k, cpu_rdata, exp_cd[k]); end
         end
         if (exp_vv[k]) begin
            n_cmp++; if (vid_rdata !== exp_vd[k]) begin n_bad++; $display("FAIL rnd_vdata k=%0d: got %h want %h", k, vid_rdata, exp_vd[k]); end
         end
         if (e_gc) begin
            if (c_we_r) ref_mem[int'(c_addr_r)] = c_wdata_r;
            else begin exp_cv[k + 3] = 1; exp_cd[k + 3] = ref_read(c_addr_r); end
            c_pend = 0;
            refused = 0;
         end else if (c_pend) begin
            refused = (refused < MAXW) ? refused + 1 : MAXW;
         end
         if (e_gv) begin
            exp_vv[k + 3] = 1; exp_vd[k + 3] = ref_read(v_addr_r);
            v_pend = 0;
         end
      end
      @(negedge clk);
      idle_inputs();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_cpu_write_read();
      test_video_burst();
      test_starvation();
      test_interleave();
      test_collision();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
